// File: rtl/pe_net_loader.sv
// pe_net_loader
//   Source-side sequencer for the PE array. For every job it strobes the
//   control configuration, shifts KTAPS weight words into each row, streams
//   num_lines x LINES pixel beats with per-row enables, drains the array for
//   DRAIN cycles and then pulses done.
//
// Ports
//   clk, rst                : clock (rising edge), asynchronous active-low reset
//   start, num_lines, cfg_* : job request and job settings, latched in IDLE
//   wt_valid/wt_ready/wt_data : weight stream, one word per row per beat
//   px_valid/px_ready/px_data : pixel stream, one pixel per row per beat
//   d_in, en_in, w_in, w_conf, cntl_conf, d_ch_in, bp_ch_in, bp_src_in
//                           : registered array-facing outputs
//   busy                    : high whenever a job is in progress
//   done                    : one-cycle completion pulse
module pe_net_loader #(
    parameter int ROW_SIZE = 8,
    parameter int LINES    = 16,
    parameter int N        = 4,
    parameter int M        = 4,
    parameter int CL_IN    = 4,
    parameter int CL1      = 2,
    parameter int KTAPS    = 9,
    parameter int DRAIN    = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [15:0]               num_lines,
    input  logic [ROW_SIZE-1:0]       cfg_row_en,
    input  logic [ROW_SIZE*CL_IN-1:0] cfg_d_ch,
    input  logic [ROW_SIZE*CL_IN-1:0] cfg_bp_ch,
    input  logic [ROW_SIZE*CL1-1:0]   cfg_bp_src,
    input  logic                      wt_valid,
    output logic                      wt_ready,
    input  logic [ROW_SIZE*M-1:0]     wt_data,
    input  logic                      px_valid,
    output logic                      px_ready,
    input  logic [ROW_SIZE*N-1:0]     px_data,
    output logic [ROW_SIZE*N-1:0]     d_in,
    output logic [ROW_SIZE-1:0]       en_in,
    output logic [ROW_SIZE*M-1:0]     w_in,
    output logic                      w_conf,
    output logic                      cntl_conf,
    output logic [ROW_SIZE*CL_IN-1:0] d_ch_in,
    output logic [ROW_SIZE*CL_IN-1:0] bp_ch_in,
    output logic [ROW_SIZE*CL1-1:0]   bp_src_in,
    output logic                      busy,
    output logic                      done
);

    localparam int TAP_W   = (KTAPS > 1) ? $clog2(KTAPS) : 1;
    localparam int COL_W   = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int DRAIN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CTRL, S_WLOAD, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t                    state_reg;
    logic [TAP_W-1:0]          tap_reg;
    logic [COL_W-1:0]          col_reg;
    logic [15:0]               line_reg;
    logic [DRAIN_W-1:0]        drain_reg;
    logic [15:0]               num_lines_reg;
    logic [ROW_SIZE-1:0]       row_en_reg;

    logic [ROW_SIZE*N-1:0]     d_in_reg;
    logic [ROW_SIZE-1:0]       en_in_reg;
    logic [ROW_SIZE*M-1:0]     w_in_reg;
    logic                      w_conf_reg;
    logic                      cntl_conf_reg;
    logic [ROW_SIZE*CL_IN-1:0] d_ch_reg;
    logic [ROW_SIZE*CL_IN-1:0] bp_ch_reg;
    logic [ROW_SIZE*CL1-1:0]   bp_src_reg;
    logic                      done_reg;

    // Readies are decoded from the state register only, so they never
    // depend combinationally on the valids.
    assign wt_ready  = (state_reg == S_WLOAD);
    assign px_ready  = (state_reg == S_STREAM);
    assign busy      = (state_reg != S_IDLE);

    assign d_in      = d_in_reg;
    assign en_in     = en_in_reg;
    assign w_in      = w_in_reg;
    assign w_conf    = w_conf_reg;
    assign cntl_conf = cntl_conf_reg;
    assign d_ch_in   = d_ch_reg;
    assign bp_ch_in  = bp_ch_reg;
    assign bp_src_in = bp_src_reg;
    assign done      = done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            tap_reg       <= '0;
            col_reg       <= '0;
            line_reg      <= '0;
            drain_reg     <= '0;
            num_lines_reg <= '0;
            row_en_reg    <= '0;
            d_in_reg      <= '0;
            en_in_reg     <= '0;
            w_in_reg      <= '0;
            w_conf_reg    <= 1'b0;
            cntl_conf_reg <= 1'b0;
            d_ch_reg      <= '0;
            bp_ch_reg     <= '0;
            bp_src_reg    <= '0;
            done_reg      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below; d_in and
            // w_in simply hold their last value on idle cycles.
            cntl_conf_reg <= 1'b0;
            w_conf_reg    <= 1'b0;
            en_in_reg     <= '0;
            done_reg      <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        num_lines_reg <= num_lines;
                        row_en_reg    <= cfg_row_en;
                        d_ch_reg      <= cfg_d_ch;
                        bp_ch_reg     <= cfg_bp_ch;
                        bp_src_reg    <= cfg_bp_src;
                        tap_reg       <= '0;
                        col_reg       <= '0;
                        line_reg      <= '0;
                        drain_reg     <= '0;
                        state_reg     <= S_CTRL;
                    end
                end

                S_CTRL: begin
                    cntl_conf_reg <= 1'b1;
                    state_reg     <= S_WLOAD;
                end

                S_WLOAD: begin
                    if (wt_valid) begin
                        w_in_reg   <= wt_data;
                        w_conf_reg <= 1'b1;
                        if (tap_reg == TAP_W'(KTAPS - 1)) begin
                            tap_reg   <= '0;
                            // An empty frame skips streaming entirely.
                            state_reg <= (num_lines_reg == 16'd0) ? S_DRAIN : S_STREAM;
                        end else begin
                            tap_reg <= tap_reg + 1'b1;
                        end
                    end
                end

                S_STREAM: begin
                    if (px_valid) begin
                        d_in_reg  <= px_data;
                        en_in_reg <= row_en_reg;
                        if (col_reg == COL_W'(LINES - 1)) begin
                            col_reg <= '0;
                            // num_lines_reg is non-zero here, so the
                            // subtraction cannot wrap.
                            if (line_reg == num_lines_reg - 16'd1) begin
                                line_reg  <= '0;
                                state_reg <= S_DRAIN;
                            end else begin
                                line_reg <= line_reg + 16'd1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_reg == DRAIN_W'(DRAIN - 1)) begin
                        drain_reg <= '0;
                        done_reg  <= 1'b1;   // high for the whole DONE cycle
                        state_reg <= S_DONE;
                    end else begin
                        drain_reg <= drain_reg + 1'b1;
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_net_loader.sv
module tb_pe_net_loader;

    localparam int ROW   = 8;
    localparam int LINES = 16;
    localparam int N     = 4;
    localparam int M     = 4;
    localparam int CL_IN = 4;
    localparam int CL1   = 2;
    localparam int KT    = 9;
    localparam int DR    = 12;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [15:0]            num_lines = '0;
    logic [ROW-1:0]         cfg_row_en = '0;
    logic [ROW*CL_IN-1:0]   cfg_d_ch = '0;
    logic [ROW*CL_IN-1:0]   cfg_bp_ch = '0;
    logic [ROW*CL1-1:0]     cfg_bp_src = '0;
    logic                   wt_valid = 1'b0;
    logic                   wt_ready;
    logic [ROW*M-1:0]       wt_data = '0;
    logic                   px_valid = 1'b0;
    logic                   px_ready;
    logic [ROW*N-1:0]       px_data = '0;
    logic [ROW*N-1:0]       d_in;
    logic [ROW-1:0]         en_in;
    logic [ROW*M-1:0]       w_in;
    logic                   w_conf;
    logic                   cntl_conf;
    logic [ROW*CL_IN-1:0]   d_ch_in;
    logic [ROW*CL_IN-1:0]   bp_ch_in;
    logic [ROW*CL1-1:0]     bp_src_in;
    logic                   busy;
    logic                   done;

    pe_net_loader #(
        .ROW_SIZE(ROW), .LINES(LINES), .N(N), .M(M),
        .CL_IN(CL_IN), .CL1(CL1), .KTAPS(KT), .DRAIN(DR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_lines(num_lines),
        .cfg_row_en(cfg_row_en), .cfg_d_ch(cfg_d_ch), .cfg_bp_ch(cfg_bp_ch),
        .cfg_bp_src(cfg_bp_src), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .wt_data(wt_data), .px_valid(px_valid), .px_ready(px_ready),
        .px_data(px_data), .d_in(d_in), .en_in(en_in), .w_in(w_in),
        .w_conf(w_conf), .cntl_conf(cntl_conf), .d_ch_in(d_ch_in),
        .bp_ch_in(bp_ch_in), .bp_src_in(bp_src_in), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROW*M-1:0] wdata(input int idx);
        logic [ROW*M-1:0] w;
        w = '0;
        for (int r = 0; r < ROW; r++) w[r*M +: M] = M'(idx + 1 + r);
        return w;
    endfunction

    // Scoreboard queues: pushed on an observed handshake, popped one cycle later.
    logic [ROW*M-1:0]     wq[$];
    logic [ROW+ROW*N-1:0] pq[$];

    int   cyc = 0;
    int   start_edge = 0, done_edge = 0;
    int   wconf_cnt = 0, en_cnt = 0, cntl_cnt = 0, done_cnt = 0;
    bit   wt_fire = 0, px_fire = 0;
    logic [ROW-1:0] cur_mask = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [ROW*M-1:0]     we;
        logic [ROW+ROW*N-1:0] pe;
        if (!rst) begin
            wq.delete();
            pq.delete();
            wt_fire = 0;
            px_fire = 0;
        end else begin
            if (wq.size() > 0) begin
                we = wq.pop_front();
                check_val("w_conf", 64'(w_conf), 64'd1);
                check_val("w_in", 64'(w_in), 64'(we));
            end else begin
                check_val("w_conf_idle", 64'(w_conf), 64'd0);
            end
            if (w_conf) wconf_cnt++;

            if (pq.size() > 0) begin
                pe = pq.pop_front();
                check_val("en_in", 64'(en_in), 64'(pe[ROW*N +: ROW]));
                check_val("d_in", 64'(d_in), 64'(pe[ROW*N-1:0]));
            end else begin
                check_val("en_in_idle", 64'(en_in), 64'd0);
            end
            if (en_in != '0) en_cnt++;

            if (cntl_conf) begin
                cntl_cnt++;
                check_val("cntl_conf_time", 64'(cyc), 64'(start_edge + 1));
            end
            if (done) begin
                done_cnt++;
                done_edge = cyc;
                check_val("busy_at_done", 64'(busy), 64'd1);
            end

            wt_fire = wt_valid && wt_ready;
            if (wt_fire) wq.push_back(wt_data);
            px_fire = px_valid && px_ready;
            if (px_fire) pq.push_back({cur_mask, px_data});
        end
    end

    function automatic bit any_out();
        return (|{wt_ready, px_ready, d_in, en_in, w_in, w_conf, cntl_conf,
                  d_ch_in, bp_ch_in, bp_src_in, busy, done});
    endfunction

    // wmode/pmode: 0 = valid always high, 1 = backpressure pattern.
    // exp_len: edges from start sample to done visible; 0 skips the check.
    task automatic run_job(input logic [15:0] nl, input logic [ROW-1:0] mask,
                           input int wmode, input int pmode,
                           input int exp_len, input int exp_en);
        logic [ROW*CL_IN-1:0] sv_d, sv_bp;
        logic [ROW*CL1-1:0]   sv_src;
        int  wt_idx;
        bit  timed_out;
        wconf_cnt = 0; en_cnt = 0; cntl_cnt = 0; done_cnt = 0;
        wt_idx = 0;
        cur_mask   = mask;
        num_lines  = nl;
        cfg_row_en = mask;
        cfg_d_ch   = $urandom;
        cfg_bp_ch  = $urandom;
        cfg_bp_src = 16'($urandom);
        sv_d = cfg_d_ch; sv_bp = cfg_bp_ch; sv_src = cfg_bp_src;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_edge = cyc;
        check_val("d_ch_in_latched", 64'(d_ch_in), 64'(sv_d));
        // Change the inputs after latching: the array-side copies must hold.
        num_lines  = 16'($urandom);
        cfg_row_en = 8'($urandom);
        cfg_d_ch   = $urandom;
        cfg_bp_ch  = $urandom;
        cfg_bp_src = 16'($urandom);
        timed_out = 1;
        for (int k = 0; k < 3000; k++) begin
            wt_valid = (wmode == 0) || (k % 2 == 0);
            wt_data  = wdata(wt_idx);
            px_valid = (pmode == 0) || (k % 3 != 2);
            px_data  = $urandom;
            @(negedge clk);
            if (done) begin
                timed_out = 0;
                break;
            end
            @(posedge clk); #1;
            if (wt_fire) wt_idx++;
        end
        check_val("job_timeout", 64'(timed_out), 64'd0);
        // A start raised during the DONE cycle must be ignored.
        start = 1'b1; wt_valid = 1'b0; px_valid = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check_val("busy_after_done", 64'(busy), 64'd0);
        @(negedge clk);
        check_val("busy_idle", 64'(busy), 64'd0);
        check_val("cntl_cnt", 64'(cntl_cnt), 64'd1);
        check_val("wconf_cnt", 64'(wconf_cnt), 64'(KT));
        check_val("en_cnt", 64'(en_cnt), 64'(exp_en));
        check_val("done_cnt", 64'(done_cnt), 64'd1);
        if (exp_len > 0) check_val("job_len", 64'(done_edge - start_edge), 64'(exp_len));
        check_val("d_ch_hold", 64'(d_ch_in), 64'(sv_d));
        check_val("bp_ch_hold", 64'(bp_ch_in), 64'(sv_bp));
        check_val("bp_src_hold", 64'(bp_src_in), 64'(sv_src));
        $display("job num_lines=%0d mask=%02h w_conf=%0d en_beats=%0d len=%0d", nl, mask,
                 wconf_cnt, en_cnt, done_edge - start_edge);
    endtask

    initial begin
        bit reached;
        // Reset held with random inputs: everything must stay at zero.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom); num_lines = 16'($urandom); cfg_row_en = 8'($urandom);
            wt_valid = 1'($urandom); px_valid = 1'($urandom);
            wt_data = $urandom; px_data = $urandom;
            @(negedge clk);
            check_val("reset_outputs", 64'(any_out()), 64'd0);
        end
        start = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("idle_busy", 64'(busy), 64'd0);
            check_val("idle_strobes", 64'({cntl_conf, done, wt_ready, px_ready}), 64'd0);
        end
        $display("reset/idle phase complete");

        // Minimal job: 1 ctrl + 9 taps + 16 pixels + 12 drain, done at +38 edges.
        run_job(16'd1, 8'hFF, 0, 0, 1 + KT + LINES + DR, LINES);
        // Backpressure on both streams.
        run_job(16'd1, 8'hFF, 1, 1, 0, LINES);
        // Row mask over two lines.
        run_job(16'd2, 8'h0F, 0, 0, 1 + KT + 2*LINES + DR, 2*LINES);
        // Empty frame: weights only, then drain.
        run_job(16'd0, 8'hFF, 0, 0, 1 + KT + DR, 0);

        // Abort during line 1 of a three-line job.
        wconf_cnt = 0; en_cnt = 0; cntl_cnt = 0; done_cnt = 0;
        cur_mask = 8'hFF; num_lines = 16'd3; cfg_row_en = 8'hFF;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_edge = cyc;
        wt_valid = 1'b1; px_valid = 1'b1; wt_data = wdata(0);
        reached = 0;
        for (int k = 0; k < 200; k++) begin
            px_data = $urandom;
            @(negedge clk);
            if (en_cnt >= LINES + 4) begin
                reached = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("abort_reached_line1", 64'(reached), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        #1 check_val("abort_outputs", 64'(any_out()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("abort_no_done", 64'(done), 64'd0);
        end
        rst = 1'b1;
        wt_valid = 1'b0; px_valid = 1'b0;
        @(negedge clk);
        check_val("abort_idle", 64'(busy), 64'd0);
        $display("abort phase complete done_pulses=%0d", done_cnt);

        // Fresh job after the abort runs to completion.
        run_job(16'd1, 8'hA5, 0, 0, 1 + KT + LINES + DR, LINES);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
